// File: rtl/apple1_pkg.sv
// Shared types and sizing for the Apple-1 RAM port arbiter.
package apple1_pkg;

    localparam int CLK_DIV_NOM = 14;
    localparam int PHASE_W     = $clog2(CLK_DIV_NOM);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_fifo.sv
// Small synchronous FIFO holding loader {addr, data} entries between CPU strobes.
module arb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    // A full FIFO refuses the push even when the same clock pops.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the external RAM port between the 6502 and the loader stream, slotting
// buffered loader writes into the free clocks between CPU enable strobes.
module ram_port_arbiter
    import apple1_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_NOM,
    parameter int GUARD      = 2,
    parameter int WR_CYCLES  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk14,
    input  logic        rst_n,
    input  logic        cpu_clken,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    input  logic        cpu_ram_cs,
    input  logic        ld_valid,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        ld_idle,
    output logic [15:0] ld_count,
    output logic        ld_collision,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_rd,
    output logic        ram_wr
);

    localparam int PW        = (PHASE_W >= $clog2(CLK_DIV)) ? PHASE_W : $clog2(CLK_DIV);
    localparam int CW        = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam int WIN_START = CLK_DIV - 1 - GUARD;

    logic [PW-1:0] phase;
    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] wr_cnt_nxt;
    logic          pop;
    logic          abort;
    logic          start_ok;
    logic          loader_on;
    logic [23:0]   head;
    logic          fifo_full;
    logic          fifo_empty;

    arb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (24)
    ) u_fifo (
        .clk   (clk14),
        .rst_n (rst_n),
        .push  (ld_valid),
        .pop   (pop),
        .wdata ({ld_addr, ld_data}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Phase restarts after each strobe and parks at CLK_DIV-1 until the next one.
    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (cpu_clken) begin
            phase <= '0;
        end else if (phase != PW'(CLK_DIV - 1)) begin
            phase <= phase + PW'(1);
        end
    end

    // A write may only start if all of its clocks finish before the CPU window.
    assign start_ok = !fifo_empty && !cpu_clken && ((int'(phase) + WR_CYCLES) < WIN_START);

    always_comb begin
        state_nxt  = state;
        wr_cnt_nxt = wr_cnt;
        pop        = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt  = WRITE;
                    wr_cnt_nxt = '0;
                end
            end
            WRITE: begin
                if (cpu_clken) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end else if (wr_cnt == CW'(WR_CYCLES - 1)) begin
                    state_nxt = IDLE;
                    pop       = 1'b1;
                end else begin
                    wr_cnt_nxt = wr_cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_cnt       <= '0;
            ld_count     <= '0;
            ld_collision <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_cnt <= wr_cnt_nxt;
            if (pop)   ld_count     <= ld_count + 16'd1;
            if (abort) ld_collision <= 1'b1;
        end
    end

    // An unexpected strobe takes the port back in the same clock.
    assign loader_on = (state == WRITE) && !cpu_clken;

    always_comb begin
        ram_addr = cpu_addr;
        ram_din  = cpu_dout;
        ram_rd   = cpu_ram_cs & rst_n;
        ram_wr   = cpu_we & cpu_ram_cs & cpu_clken & rst_n;
        if (loader_on) begin
            ram_addr = head[23:8];
            ram_din  = head[7:0];
            ram_rd   = 1'b0;
            ram_wr   = 1'b1;
        end
    end

    assign ld_ready = !fifo_full;
    assign ld_idle  = fifo_empty && (state == IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_ram_port_arbiter;

    localparam int CLK_DIV   = 14;
    localparam int GUARD     = 2;
    localparam int WR_CYCLES = 2;
    localparam int DEPTH     = 4;
    localparam int WIN_START = CLK_DIV - 1 - GUARD;

    logic        clk14;
    logic        rst_n;
    logic        cpu_clken;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic        cpu_ram_cs;
    logic        ld_valid;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        ld_idle;
    logic [15:0] ld_count;
    logic        ld_collision;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_rd;
    logic        ram_wr;

    ram_port_arbiter #(
        .CLK_DIV    (CLK_DIV),
        .GUARD      (GUARD),
        .WR_CYCLES  (WR_CYCLES),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk14        (clk14),
        .rst_n        (rst_n),
        .cpu_clken    (cpu_clken),
        .cpu_addr     (cpu_addr),
        .cpu_dout     (cpu_dout),
        .cpu_we       (cpu_we),
        .cpu_ram_cs   (cpu_ram_cs),
        .ld_valid     (ld_valid),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .ld_idle      (ld_idle),
        .ld_count     (ld_count),
        .ld_collision (ld_collision),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_rd       (ram_rd),
        .ram_wr       (ram_wr)
    );

    initial clk14 = 1'b0;
    always #5 clk14 = ~clk14;

    int          tests = 0;
    int          fails = 0;
    logic [23:0] q[$];
    logic [15:0] committed = '0;
    int          ph = 0;
    int          run = 0;
    bit          coll_exp = 1'b0;
    int          lwr_clocks = 0;
    int          last_start_ph = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: strobe generation, output checks, then model update at the edge.
    task automatic step(input bit force_stb);
        bit lwr;
        bit acc;
        bit popm;
        cpu_clken = force_stb || (ph == CLK_DIV - 1);
        #1;
        lwr  = ram_wr && !cpu_clken;
        popm = 1'b0;
        chk("ld_ready", 32'(ld_ready), 32'(q.size() < DEPTH));
        chk("ld_idle", 32'(ld_idle), 32'(q.size() == 0));
        chk("ld_count", 32'(ld_count), 32'(committed));
        chk("ld_collision", 32'(ld_collision), 32'(coll_exp));
        if (lwr) begin
            chk("lwr_window", 32'(ph < WIN_START), 32'(1));
            chk("lwr_rd", 32'(ram_rd), 32'(0));
            chk("lwr_pending", 32'(q.size() != 0), 32'(1));
            if (q.size() != 0) begin
                chk("lwr_addr", 32'(ram_addr), 32'(q[0][23:8]));
                chk("lwr_din", 32'(ram_din), 32'(q[0][7:0]));
            end
            if (run == 0) last_start_ph = ph;
            lwr_clocks++;
            run++;
            if (run == WR_CYCLES) begin
                popm = 1'b1;
                run  = 0;
            end
        end else begin
            run = 0;
            chk("cpu_addr", 32'(ram_addr), 32'(cpu_addr));
            chk("cpu_din", 32'(ram_din), 32'(cpu_dout));
            chk("cpu_rd", 32'(ram_rd), 32'(cpu_ram_cs));
            chk("cpu_wr", 32'(ram_wr), 32'(cpu_we & cpu_ram_cs & cpu_clken));
        end
        acc = ld_valid && (q.size() < DEPTH);
        @(posedge clk14);
        #1;
        if (popm && q.size() != 0) begin
            void'(q.pop_front());
            committed++;
        end
        if (acc) q.push_back({ld_addr, ld_data});
        ph = cpu_clken ? 0 : ((ph < CLK_DIV - 1) ? ph + 1 : ph);
    endtask

    task automatic idle_inputs();
        ld_valid   = 1'b0;
        ld_addr    = 16'h0000;
        ld_data    = 8'h00;
        cpu_addr   = 16'hE000;
        cpu_dout   = 8'h00;
        cpu_we     = 1'b0;
        cpu_ram_cs = 1'b1;
    endtask

    task automatic wait_ph(input int p);
        for (int i = 0; i < 40 && ph != p; i++) step(1'b0);
        chk("wait_phase", 32'(ph), 32'(p));
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && q.size() != 0; i++) step(1'b0);
        step(1'b0);
        chk("drain_empty", 32'(q.size()), 32'(0));
        chk("drain_idle", 32'(ld_idle), 32'(1));
    endtask

    task automatic push_one(input logic [15:0] a, input logic [7:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        step(1'b0);
        ld_valid = 1'b0;
    endtask

    initial begin
        int          base;
        int          pushed;
        int          wr_before;
        bit          acc;
        rst_n      = 1'b1;
        cpu_clken  = 1'b0;
        ld_valid   = 1'b0;
        ld_addr    = '0;
        ld_data    = '0;
        cpu_addr   = '0;
        cpu_dout   = '0;
        cpu_we     = 1'b0;
        cpu_ram_cs = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk14);
        @(posedge clk14);
        #1;
        chk("rst_ready", 32'(ld_ready), 32'(1));
        chk("rst_idle", 32'(ld_idle), 32'(1));
        chk("rst_count", 32'(ld_count), 32'(0));
        chk("rst_coll", 32'(ld_collision), 32'(0));
        chk("rst_wr", 32'(ram_wr), 32'(0));
        chk("rst_rd", 32'(ram_rd), 32'(0));
        chk("rst_addr", 32'(ram_addr), 32'(0));
        chk("rst_din", 32'(ram_din), 32'(0));
        rst_n = 1'b1;
        idle_inputs();

        // Idle traffic: CPU strobes only.
        for (int i = 0; i < 30; i++) step(1'b0);

        // Single loader byte pushed at phase 1.
        wait_ph(1);
        wr_before = lwr_clocks;
        push_one(16'h0280, 8'hA9);
        for (int i = 0; i < 12; i++) step(1'b0);
        chk("single_len", 32'(lwr_clocks - wr_before), 32'(WR_CYCLES));
        chk("single_start", 32'(last_start_ph), 32'(3));
        chk("single_count", 32'(ld_count), 32'(1));
        chk("single_idle", 32'(ld_idle), 32'(1));

        // Six bytes with ld_valid held, starting late enough to fill the FIFO.
        wait_ph(9);
        base   = int'(committed);
        pushed = 0;
        for (int i = 0; i < 200 && pushed < 6; i++) begin
            ld_valid = 1'b1;
            ld_addr  = 16'h1000 + 16'(pushed);
            ld_data  = 8'h10 + 8'(pushed);
            acc      = (q.size() < DEPTH);
            step(1'b0);
            if (acc) begin
                pushed++;
                if (pushed == DEPTH) chk("burst_full", 32'(ld_ready), 32'(0));
            end
        end
        ld_valid = 1'b0;
        chk("burst_pushed", 32'(pushed), 32'(6));
        drain();
        chk("burst_count", 32'(ld_count), 32'(base + 6));

        // CPU write strobe while loader entries are pending.
        wait_ph(9);
        push_one(16'h2000, 8'h01);
        push_one(16'h2001, 8'h02);
        wait_ph(CLK_DIV - 1);
        cpu_we   = 1'b1;
        cpu_addr = 16'h0300;
        cpu_dout = 8'h55;
        step(1'b0);
        idle_inputs();
        drain();

        // Random loader and CPU traffic.
        for (int i = 0; i < 700; i++) begin
            ld_valid   = 1'($urandom_range(0, 1));
            ld_addr    = 16'($urandom);
            ld_data    = 8'($urandom);
            cpu_addr   = 16'($urandom);
            cpu_dout   = 8'($urandom);
            cpu_we     = 1'($urandom_range(0, 1));
            cpu_ram_cs = 1'($urandom_range(0, 1));
            step(1'b0);
        end
        idle_inputs();
        drain();

        // Early strobe lands in the first WRITE clock (phase 5).
        wait_ph(3);
        base = int'(committed);
        push_one(16'h0400, 8'h77);
        step(1'b0);
        chk("abort_phase", 32'(ph), 32'(5));
        step(1'b1);
        coll_exp = 1'b1;
        chk("abort_coll", 32'(ld_collision), 32'(1));
        drain();
        chk("abort_count", 32'(ld_count), 32'(base + 1));

        // Reset asserted while a loader write drives the port.
        wait_ph(1);
        push_one(16'h0500, 8'h11);
        push_one(16'h0501, 8'h22);
        for (int i = 0; i < 20 && ram_wr !== 1'b1; i++) step(1'b0);
        chk("midwr_active", 32'(ram_wr), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("midwr_async_wr", 32'(ram_wr), 32'(0));
        q.delete();
        committed = '0;
        run       = 0;
        coll_exp  = 1'b0;
        ph        = 0;
        @(posedge clk14);
        @(posedge clk14);
        #1;
        rst_n = 1'b1;
        chk("post_rst_idle", 32'(ld_idle), 32'(1));
        chk("post_rst_count", 32'(ld_count), 32'(0));
        chk("post_rst_ready", 32'(ld_ready), 32'(1));
        for (int i = 0; i < 20; i++) step(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
